// File: rtl/rv_pkg.sv
// Shared RV32I definitions for the multicycle control unit and the execute stage.
// Holds opcode constants, ALU/branch operation codes, the control FSM state type,
// the immediate/writeback/PC select encodings and the ALU funct3 decode helper.
package rv_pkg;

  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  // Arithmetic operation codes on alu_ctrl.
  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLL  = 4'd2;
  localparam logic [3:0] ALU_SLT  = 4'd3;
  localparam logic [3:0] ALU_SLTU = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_OR   = 4'd8;
  localparam logic [3:0] ALU_AND  = 4'd9;

  // Compare operation codes on alu_ctrl while a branch is in EXEC.
  localparam logic [3:0] BR_EQ  = 4'd0;
  localparam logic [3:0] BR_NE  = 4'd1;
  localparam logic [3:0] BR_LT  = 4'd2;
  localparam logic [3:0] BR_GE  = 4'd3;
  localparam logic [3:0] BR_LTU = 4'd4;
  localparam logic [3:0] BR_GEU = 4'd5;

  typedef enum logic [2:0] {
    ST_FETCH, ST_DECODE, ST_EXEC, ST_MEM, ST_WB, ST_TRAP
  } state_e;

  typedef enum logic [2:0] {IMM_I = 3'd0, IMM_S = 3'd1, IMM_B = 3'd2, IMM_U = 3'd3, IMM_J = 3'd4} imm_sel_e;
  typedef enum logic [1:0] {WB_ALU = 2'd0, WB_MEM = 2'd1, WB_PC4 = 2'd2, WB_IMM = 2'd3} wb_sel_e;
  typedef enum logic [1:0] {PC_SEQ = 2'd0, PC_REL = 2'd1, PC_ALU = 2'd2} pc_sel_e;

  typedef enum logic [3:0] {
    CL_OP, CL_OPIMM, CL_BRANCH, CL_LOAD, CL_STORE, CL_JAL,
    CL_JALR, CL_LUI, CL_AUIPC, CL_FENCE, CL_ILLEGAL
  } instr_class_e;

  // funct3 -> ALU op; alt selects SUB/SRA (funct7[5]).
  function automatic logic [3:0] alu_op_decode(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  return alt ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/mc_ctrl_decode.sv
// Combinational instruction decoder for the multicycle control unit.
// Ports: instr_i (IR contents) -> cls_o (instruction class), alu_ctrl_o (ALU/compare op),
//        imm_sel_o (immediate format), illegal_o (unsupported encoding, ECALL/EBREAK/CSR).
module mc_ctrl_decode
  import rv_pkg::*;
#(
  parameter bit STRICT_DECODE = 1'b1
) (
  input  logic [31:0]  instr_i,
  output instr_class_e cls_o,
  output logic [3:0]   alu_ctrl_o,
  output imm_sel_e     imm_sel_o,
  output logic         illegal_o
);

  logic [6:0] opc;
  logic [2:0] f3;
  logic [6:0] f7;
  logic       f7_ok;    // funct7 is 0x00 or the 0x20 alternate encoding
  logic       unused_fields;

  assign opc   = instr_i[6:0];
  assign f3    = instr_i[14:12];
  assign f7    = instr_i[31:25];
  assign f7_ok = (f7 == 7'h00) || (f7 == 7'h20);
  // Register and rd/immediate fields are consumed by the datapath, not here.
  assign unused_fields = ^{instr_i[24:15], instr_i[11:7]};

  always_comb begin
    cls_o      = CL_ILLEGAL;
    alu_ctrl_o = ALU_ADD;
    imm_sel_o  = IMM_I;
    illegal_o  = 1'b0;
    case (opc)
      OPC_OP: begin
        cls_o      = CL_OP;
        alu_ctrl_o = alu_op_decode(f3, f7[5]);
        // Only SUB and SRA own the 0x20 alternate; anything else (e.g. M-ext) traps.
        if (STRICT_DECODE)
          illegal_o = !((f7 == 7'h00) || ((f7 == 7'h20) && ((f3 == 3'b000) || (f3 == 3'b101))));
      end
      OPC_OP_IMM: begin
        cls_o      = CL_OPIMM;
        alu_ctrl_o = alu_op_decode(f3, (f3 == 3'b101) && f7[5]);
        if (STRICT_DECODE) begin
          if (f3 == 3'b001) illegal_o = (f7 != 7'h00);
          if (f3 == 3'b101) illegal_o = !f7_ok;
        end
      end
      OPC_BRANCH: begin
        cls_o     = CL_BRANCH;
        imm_sel_o = IMM_B;
        case (f3)
          3'b000:  alu_ctrl_o = BR_EQ;
          3'b001:  alu_ctrl_o = BR_NE;
          3'b100:  alu_ctrl_o = BR_LT;
          3'b101:  alu_ctrl_o = BR_GE;
          3'b110:  alu_ctrl_o = BR_LTU;
          3'b111:  alu_ctrl_o = BR_GEU;
          default: illegal_o  = 1'b1;
        endcase
      end
      OPC_LOAD: begin
        cls_o     = CL_LOAD;
        illegal_o = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
      end
      OPC_STORE: begin
        cls_o     = CL_STORE;
        imm_sel_o = IMM_S;
        illegal_o = f3[2] || (f3[1:0] == 2'b11);
      end
      OPC_JAL: begin
        cls_o     = CL_JAL;
        imm_sel_o = IMM_J;
      end
      OPC_JALR: begin
        cls_o     = CL_JALR;
        illegal_o = (f3 != 3'b000);
      end
      OPC_LUI: begin
        cls_o     = CL_LUI;
        imm_sel_o = IMM_U;
      end
      OPC_AUIPC: begin
        cls_o     = CL_AUIPC;
        imm_sel_o = IMM_U;
      end
      OPC_MISC_MEM: cls_o = CL_FENCE;   // in-order single-issue core: fences are no-ops
      // ECALL, EBREAK and CSR accesses all stop the core in TRAP.
      OPC_SYSTEM:   illegal_o = 1'b1;
      default:      illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multicycle RV32I control unit: sequences FETCH/DECODE/EXEC/MEM/WB, drives all datapath
// strobes/selects and the memory req/ready handshake; traps on illegal/ECALL/EBREAK.
// Ports: clk, rst (sync, active-high), instr, br_en, mem_ready in; memory, datapath, trap out.
// Macro MC_CTRL_INSTRET_EN adds the instret retired-instruction counter port.
module mc_ctrl_fsm
  import rv_pkg::*;
#(
  parameter bit STRICT_DECODE = 1'b1,
  parameter int INSTRET_W     = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic        br_en,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic        addr_sel,
  output logic        ir_we,
  output logic        ab_we,
  output logic        alu_src_a,
  output logic        alu_src_b,
  output logic [3:0]  alu_ctrl,
  output logic        alu_out_we,
  output logic [2:0]  imm_sel,
  output logic        rf_we,
  output logic [1:0]  wb_sel,
  output logic        pc_we,
  output logic [1:0]  pc_sel,
  output logic        trap
`ifdef MC_CTRL_INSTRET_EN
  ,
  output logic [INSTRET_W-1:0] instret
`endif
);

  state_e       state_q, state_d;
  logic         trap_q, trap_d;
  logic         retire;
  instr_class_e dec_cls;
  logic [3:0]   dec_alu_ctrl;
  imm_sel_e     dec_imm_sel;
  logic         dec_illegal;

  mc_ctrl_decode #(.STRICT_DECODE(STRICT_DECODE)) u_decode (
    .instr_i    (instr),
    .cls_o      (dec_cls),
    .alu_ctrl_o (dec_alu_ctrl),
    .imm_sel_o  (dec_imm_sel),
    .illegal_o  (dec_illegal)
  );

  always_comb begin
    state_d    = state_q;
    trap_d     = trap_q;
    retire     = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    addr_sel   = 1'b0;
    ir_we      = 1'b0;
    ab_we      = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 1'b0;
    alu_ctrl   = ALU_ADD;
    alu_out_we = 1'b0;
    imm_sel    = IMM_I;
    rf_we      = 1'b0;
    wb_sel     = WB_ALU;
    pc_we      = 1'b0;
    pc_sel     = PC_SEQ;
    // Reset overrides the whole decode so a pending request drops in the reset cycle itself.
    if (!rst) begin
      case (state_q)
        ST_FETCH: begin
          mem_req = 1'b1;
          ir_we   = mem_ready;
          if (mem_ready) state_d = ST_DECODE;
        end
        ST_DECODE: begin
          ab_we = 1'b1;
          if (dec_illegal) begin
            state_d = ST_TRAP;
            trap_d  = 1'b1;
          end else begin
            state_d = ST_EXEC;
          end
        end
        ST_EXEC: begin
          alu_ctrl = dec_alu_ctrl;
          imm_sel  = dec_imm_sel;
          case (dec_cls)
            CL_OP:    begin alu_out_we = 1'b1; state_d = ST_WB; end
            CL_OPIMM, CL_JALR: begin
              alu_src_b = 1'b1; alu_out_we = 1'b1; state_d = ST_WB;
            end
            CL_LOAD, CL_STORE: begin
              alu_src_b = 1'b1; alu_out_we = 1'b1; state_d = ST_MEM;
            end
            CL_AUIPC: begin
              alu_src_a = 1'b1; alu_src_b = 1'b1; alu_out_we = 1'b1; state_d = ST_WB;
            end
            CL_JAL, CL_LUI: state_d = ST_WB;
            CL_BRANCH: begin
              pc_we   = 1'b1;
              pc_sel  = br_en ? PC_REL : PC_SEQ;
              retire  = 1'b1;
              state_d = ST_FETCH;
            end
            default: begin   // FENCE; illegal encodings never leave DECODE
              pc_we   = 1'b1;
              retire  = 1'b1;
              state_d = ST_FETCH;
            end
          endcase
        end
        ST_MEM: begin
          mem_req  = 1'b1;
          addr_sel = 1'b1;
          mem_we   = (dec_cls == CL_STORE);
          if (mem_ready) begin
            if (dec_cls == CL_STORE) begin
              pc_we   = 1'b1;
              retire  = 1'b1;
              state_d = ST_FETCH;
            end else begin
              state_d = ST_WB;
            end
          end
        end
        ST_WB: begin
          imm_sel = dec_imm_sel;   // immediate feeds LUI writeback and the JAL target
          rf_we   = (instr[11:7] != 5'd0);
          pc_we   = 1'b1;
          retire  = 1'b1;
          state_d = ST_FETCH;
          case (dec_cls)
            CL_LOAD: wb_sel = WB_MEM;
            CL_JAL:  begin wb_sel = WB_PC4; pc_sel = PC_REL; end
            CL_JALR: begin wb_sel = WB_PC4; pc_sel = PC_ALU; end
            CL_LUI:  wb_sel = WB_IMM;
            default: wb_sel = WB_ALU;
          endcase
        end
        default: state_d = ST_TRAP;   // TRAP holds until reset
      endcase
    end
  end

  assign trap = trap_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_FETCH;
      trap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      trap_q  <= trap_d;
    end
  end

`ifdef MC_CTRL_INSTRET_EN
  logic [INSTRET_W-1:0] instret_q;

  always_ff @(posedge clk) begin
    if (rst)         instret_q <= '0;
    else if (retire) instret_q <= instret_q + INSTRET_W'(1);
  end

  assign instret = instret_q;
`else
  // Without the counter the width parameter and retire pulse have no consumer.
  logic [31:0] unused_instret;
  assign unused_instret = 32'(INSTRET_W) ^ {31'd0, retire};
`endif

endmodule
